// File: rtl/fetch_stage_pkg.sv
// Shared constants and the fetch-address legality helper for the fetch stage.
// The helper is only consulted when FETCH_ADEL_CHECK_EN is defined.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;

    // A fetch address is illegal when misaligned or outside instruction memory.
    function automatic logic adel_check(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IMEM_LO) || (addr > IMEM_HI);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: exception entry beats stall, stall beats the
// ordinary load of pcNext (which also covers an eret flush).
module fetch_pc_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        exc_req,
    output logic [31:0] pc
);

    logic [31:0] pc_r;

    // PC update with exception > stall > load priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (exc_req) begin
            pc_r <= EXC_VECTOR;
        end else if (!stall) begin
            pc_r <= pc_next;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Define FETCH_ADEL_CHECK_EN to flag misaligned/out-of-range fetches as AdEL.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcNext,
    input  logic        bdIn,
    input  logic        stall,
    input  logic        flush,
    input  logic        excReq,
    input  logic [31:0] instrIn,
    output logic [31:0] iAddr,
    output logic [31:0] pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_bd,
    output logic [4:0]  D_excCode
);

    logic [31:0] pc_s;
    logic        fetch_exc_s;
    logic [31:0] adv_instr_s;
    logic [4:0]  adv_exc_s;
    logic [31:0] d_instr_r;
    logic [31:0] d_pc_r;
    logic        d_bd_r;
    logic [4:0]  d_exc_r;

    fetch_pc_reg u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .pc_next (pcNext),
        .stall   (stall),
        .exc_req (excReq),
        .pc      (pc_s)
    );

`ifdef FETCH_ADEL_CHECK_EN
    assign fetch_exc_s = adel_check(pc_s);
`else
    assign fetch_exc_s = 1'b0;
`endif

    // Squash the fetched word when its address is illegal
    always_comb begin
        adv_instr_s = instrIn;
        adv_exc_s   = EXC_NONE;
        if (fetch_exc_s) begin
            adv_instr_s = 32'h0000_0000;
            adv_exc_s   = EXC_ADEL;
        end else begin
            adv_instr_s = instrIn;
            adv_exc_s   = EXC_NONE;
        end
    end

    // IF/ID register; flush only takes effect once the stall has dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_instr_r <= 32'h0000_0000;
            d_pc_r    <= 32'h0000_0000;
            d_bd_r    <= 1'b0;
            d_exc_r   <= EXC_NONE;
        end else if (excReq || (flush && !stall)) begin
            d_instr_r <= 32'h0000_0000;
            d_pc_r    <= 32'h0000_0000;
            d_bd_r    <= 1'b0;
            d_exc_r   <= EXC_NONE;
        end else if (!stall) begin
            d_instr_r <= adv_instr_s;
            d_pc_r    <= pc_s;
            d_bd_r    <= bdIn;
            d_exc_r   <= adv_exc_s;
        end else begin
            d_instr_r <= d_instr_r;
            d_pc_r    <= d_pc_r;
            d_bd_r    <= d_bd_r;
            d_exc_r   <= d_exc_r;
        end
    end

    assign iAddr     = pc_s;
    assign pc        = pc_s;
    assign D_instr   = d_instr_r;
    assign D_pc      = d_pc_r;
    assign D_bd      = d_bd_r;
    assign D_excCode = d_exc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the expected state after
// each edge, the monitor pops and compares just after that edge.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d_instr;
        logic [31:0] d_pc;
        logic        d_bd;
        logic [4:0]  d_exc;
    } exp_t;

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcNext = 32'h0;
    logic        bdIn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        excReq = 1'b0;
    logic [31:0] instrIn = 32'h0;
    logic [31:0] iAddr;
    logic [31:0] pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic        D_bd;
    logic [4:0]  D_excCode;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .pcNext    (pcNext),
        .bdIn      (bdIn),
        .stall     (stall),
        .flush     (flush),
        .excReq    (excReq),
        .instrIn   (instrIn),
        .iAddr     (iAddr),
        .pc        (pc),
        .D_instr   (D_instr),
        .D_pc      (D_pc),
        .D_bd      (D_bd),
        .D_excCode (D_excCode)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected post-edge state
    task automatic cyc(input logic rst, input logic [31:0] pn, input logic bd, input logic st,
                       input logic fl, input logic ex, input logic [31:0] ins,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_dpc, input logic e_bd, input logic [4:0] e_exc);
        exp_t e;
        @(negedge clk);
        reset = rst; pcNext = pn; bdIn = bd; stall = st; flush = fl; excReq = ex; instrIn = ins;
        e.pc = e_pc; e.d_instr = e_instr; e.d_pc = e_pc == e_pc ? e_dpc : e_dpc;
        e.d_bd = e_bd; e.d_exc = e_exc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the queued expectation just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc", pc, e.pc);
                cmp("iAddr", iAddr, e.pc);
                cmp("D_instr", D_instr, e.d_instr);
                cmp("D_pc", D_pc, e.d_pc);
                cmp("D_bd", {31'h0, D_bd}, {31'h0, e.d_bd});
                cmp("D_excCode", {27'h0, D_excCode}, {27'h0, e.d_exc});
            end
        end
    end

    initial begin
        logic [31:0] bad3002_i, bad7000_i, bad2ffc_i;
        logic [4:0]  bad_c;
        bad3002_i = ADEL_ON ? 32'h0 : 32'h8888_8888;
        bad7000_i = ADEL_ON ? 32'h0 : 32'h9999_9999;
        bad2ffc_i = ADEL_ON ? 32'h0 : 32'hBBBB_BBBB;
        bad_c     = ADEL_ON ? 5'd4 : 5'd0;

        //   rst   pcNext        bd    st    fl    ex    instrIn        pc            D_instr        D_pc          bd    exc
        cyc(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C01_0001, 32'h0000_3000, 32'h0,         32'h0,         1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C01_0001, 32'h0000_3004, 32'h3C01_0001, 32'h0000_3000, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 32'h0000_3008, 32'h1111_1111, 32'h0000_3004, 1'b1, 5'd0);
        cyc(1'b0, 32'h0000_300C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 32'h0000_300C, 32'h2222_2222, 32'h0000_3008, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0000_3010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3333_3333, 32'h0000_300C, 32'h2222_2222, 32'h0000_3008, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4444_4444, 32'h0000_3010, 32'h4444_4444, 32'h0000_300C, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_5555, 32'h0000_3008, 32'h5555_5555, 32'h0000_3010, 1'b0, 5'd0);
        // exception entry wins over stall
        cyc(1'b0, 32'h0000_3014, 1'b1, 1'b1, 1'b0, 1'b1, 32'h6666_0000, 32'h0000_4180, 32'h0,         32'h0,         1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3018, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6666_6666, 32'h0000_3018, 32'h6666_6666, 32'h0000_4180, 1'b0, 5'd0);
        // flush held off by stall, then taken
        cyc(1'b0, 32'h0000_3020, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_3018, 32'h6666_6666, 32'h0000_4180, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3020, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_3020, 32'h0,         32'h0,         1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3024, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7777_7777, 32'h0000_3024, 32'h7777_7777, 32'h0000_3020, 1'b1, 5'd0);
        // address-check boundaries
        cyc(1'b0, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8888_0000, 32'h0000_3002, 32'h8888_0000, 32'h0000_3024, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8888_8888, 32'h0000_7000, bad3002_i,     32'h0000_3002, 1'b0, bad_c);
        cyc(1'b0, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h9999_9999, 32'h0000_3000, bad7000_i,     32'h0000_7000, 1'b0, bad_c);
        cyc(1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0000_2FFC, 32'hAAAA_AAAA, 32'h0000_3000, 1'b0, 5'd0);
        cyc(1'b0, 32'h0000_6FFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBBBB_BBBB, 32'h0000_6FFC, bad2ffc_i,     32'h0000_2FFC, 1'b0, bad_c);
        cyc(1'b0, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCCCC_CCCC, 32'h0000_3000, 32'hCCCC_CCCC, 32'h0000_6FFC, 1'b1, 5'd0);
        // reset during a stall overrides everything
        cyc(1'b1, 32'h0000_3010, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDDDD_DDDD, 32'h0000_3000, 32'h0,         32'h0,         1'b0, 5'd0);
        cyc(1'b0, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, 32'hEEEE_EEEE, 32'h0000_3004, 32'hEEEE_EEEE, 32'h0000_3000, 1'b0, 5'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
